quadra_inv: RTL and testbench

- Inverse of the piecewise-quadratic evaluator. Given a target y, it finds the largest 24-bit x whose f(x) satisfies the target condition.
- Uses successive approximation, one result bit per iteration.
- The evaluator itself is external. This block drives eval_x and samples eval_y after a fixed pipeline latency.
- Sits beside the quadra evaluator under quadra_inv_top and serves requests through a valid/ready handshake.

---
 rtl/quadra_pkg.sv | 19 +
 rtl/quadra_inv.sv | 139 +++++++++++++
 tb/tb_quadra_inv.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/quadra_pkg.sv
// Shared types and constants for the quadra evaluator and its inverse search block.
package quadra_pkg;

    localparam int unsigned QUADRA_XW  = 24;
    localparam int unsigned QUADRA_YW  = 25;
    localparam int unsigned QUADRA_LAT = 3;

    typedef logic        [QUADRA_XW-1:0] x_t;
    typedef logic signed [QUADRA_YW-1:0] y_t;
    typedef logic signed [QUADRA_YW:0]   res_t;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StVerify,
        StDone
    } inv_state_e;

endpackage

// File: rtl/quadra_inv.sv
// Successive-approximation inverse of an external pipelined evaluator: finds the largest x
// whose f(x) meets the target condition, one result bit per LAT+1 cycles.
module quadra_inv
    import quadra_pkg::*;
#(
    parameter int unsigned XW         = QUADRA_XW,
    parameter int unsigned YW         = QUADRA_YW,
    parameter int unsigned LAT        = QUADRA_LAT,
    parameter int unsigned INCREASING = 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [YW-1:0] in_y,
    output logic [XW-1:0] eval_x,
    input  logic [YW-1:0] eval_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic [YW:0]   out_res,
    output logic          out_miss
);

    localparam int unsigned BW = (XW > 1) ? $clog2(XW) : 1;
    localparam int unsigned WW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [WW-1:0] LatW = WW'(LAT);
    localparam logic [BW-1:0] TopBit = BW'(XW - 1);

    inv_state_e    state_q, state_d;
    logic [YW-1:0] target_q, target_d;
    logic [XW-1:0] acc_q, acc_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [XW-1:0] eval_x_q, eval_x_d;
    logic [XW-1:0] out_x_q, out_x_d;
    logic [YW:0]   out_res_q, out_res_d;
    logic          out_miss_q, out_miss_d;
    logic          cond;
    logic [XW-1:0] acc_upd;

    function automatic logic cond_met(input logic [YW-1:0] y, input logic [YW-1:0] t);
        if (INCREASING != 0) begin
            return $signed(y) <= $signed(t);
        end
        return $signed(y) >= $signed(t);
    endfunction

    assign cond    = cond_met(eval_y, target_q);
    assign acc_upd = cond ? eval_x_q : acc_q;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        acc_d      = acc_q;
        bit_d      = bit_q;
        wcnt_d     = wcnt_q;
        eval_x_d   = eval_x_q;
        out_x_d    = out_x_q;
        out_res_d  = out_res_q;
        out_miss_d = out_miss_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    target_d = in_y;
                    acc_d    = '0;
                    bit_d    = TopBit;
                    eval_x_d = XW'(1) << TopBit;
                    wcnt_d   = '0;
                    state_d  = StSearch;
                end
            end
            StSearch: begin
                // eval_y only reflects eval_x once the full pipeline latency has elapsed
                if (wcnt_q != LatW) begin
                    wcnt_d = wcnt_q + 1'b1;
                end else begin
                    acc_d  = acc_upd;
                    wcnt_d = '0;
                    if (bit_q != '0) begin
                        bit_d    = bit_q - 1'b1;
                        eval_x_d = acc_upd | (XW'(1) << (bit_q - 1'b1));
                    end else begin
                        eval_x_d = acc_upd;
                        state_d  = StVerify;
                    end
                end
            end
            StVerify: begin
                if (wcnt_q != LatW) begin
                    wcnt_d = wcnt_q + 1'b1;
                end else begin
                    out_x_d    = acc_q;
                    out_res_d  = {target_q[YW-1], target_q} - {eval_y[YW-1], eval_y};
                    out_miss_d = !cond;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= StIdle;
            target_q   <= '0;
            acc_q      <= '0;
            bit_q      <= '0;
            wcnt_q     <= '0;
            eval_x_q   <= '0;
            out_x_q    <= '0;
            out_res_q  <= '0;
            out_miss_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            acc_q      <= acc_d;
            bit_q      <= bit_d;
            wcnt_q     <= wcnt_d;
            eval_x_q   <= eval_x_d;
            out_x_q    <= out_x_d;
            out_res_q  <= out_res_d;
            out_miss_q <= out_miss_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign eval_x    = eval_x_q;
    assign out_x     = out_x_q;
    assign out_res   = out_res_q;
    assign out_miss  = out_miss_q;

endmodule

// File: tb/tb_quadra_inv.sv
// Directed bench for quadra_inv: three builds (default, decreasing, LAT=5) each fed by a
// behavioural evaluator pipeline.
module tb_quadra_inv;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-build signals: a = default, d = INCREASING=0, l = LAT=5
    logic        a_in_valid = 0, d_in_valid = 0, l_in_valid = 0;
    logic        a_in_ready, d_in_ready, l_in_ready;
    logic [24:0] a_in_y = '0, d_in_y = '0, l_in_y = '0;
    logic [23:0] a_eval_x, d_eval_x, l_eval_x;
    logic [24:0] a_eval_y, d_eval_y, l_eval_y;
    logic        a_out_valid, d_out_valid, l_out_valid;
    logic        a_out_ready = 0, d_out_ready = 0, l_out_ready = 0;
    logic [23:0] a_out_x, d_out_x, l_out_x;
    logic [25:0] a_out_res, d_out_res, l_out_res;
    logic        a_out_miss, d_out_miss, l_out_miss;

    bit          a_mode = 0;  // 0: f(x)=x, 1: f(x)=2x
    logic [24:0] a_pipe [3];
    logic [24:0] d_pipe [3];
    logic [24:0] l_pipe [5];

    // 2x saturates so the model stays monotonic within the signed 25-bit range
    function automatic logic [24:0] fa(input logic [23:0] x);
        if (!a_mode) return {1'b0, x};
        if (x[23]) return 25'h0FF_FFFF;
        return {x, 1'b0};
    endfunction

    always @(posedge clk) begin
        a_pipe[0] <= fa(a_eval_x);
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
        d_pipe[0] <= -{1'b0, d_eval_x};
        d_pipe[1] <= d_pipe[0];
        d_pipe[2] <= d_pipe[1];
        l_pipe[0] <= {1'b0, l_eval_x};
        for (int i = 1; i < 5; i++) l_pipe[i] <= l_pipe[i-1];
    end
    assign a_eval_y = a_pipe[2];
    assign d_eval_y = d_pipe[2];
    assign l_eval_y = l_pipe[4];

    quadra_inv u_dut_a (
        .clk(clk), .rst_b(rst_b), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_y(a_in_y),
        .eval_x(a_eval_x), .eval_y(a_eval_y), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_x(a_out_x), .out_res(a_out_res), .out_miss(a_out_miss)
    );

    quadra_inv #(.INCREASING(0)) u_dut_d (
        .clk(clk), .rst_b(rst_b), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_y(d_in_y),
        .eval_x(d_eval_x), .eval_y(d_eval_y), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_x(d_out_x), .out_res(d_out_res), .out_miss(d_out_miss)
    );

    quadra_inv #(.LAT(5)) u_dut_l (
        .clk(clk), .rst_b(rst_b), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_y(l_in_y),
        .eval_x(l_eval_x), .eval_y(l_eval_y), .out_valid(l_out_valid), .out_ready(l_out_ready),
        .out_x(l_out_x), .out_res(l_out_res), .out_miss(l_out_miss)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input int which, input logic v, input logic [24:0] y);
        case (which)
            0: begin a_in_valid = v; a_in_y = y; end
            1: begin d_in_valid = v; d_in_y = y; end
            default: begin l_in_valid = v; l_in_y = y; end
        endcase
    endtask

    function automatic logic valid_of(input int which);
        case (which)
            0: return a_out_valid;
            1: return d_out_valid;
            default: return l_out_valid;
        endcase
    endfunction

    // Issue one request and count edges from the accepting edge until out_valid
    task automatic request(input int which, input logic [24:0] y, input bit inject,
                           output int edges);
        set_in(which, 1'b1, y);
        @(posedge clk); #1;
        set_in(which, 1'b0, 25'h1AB_CDEF);
        edges = 0;
        while (!valid_of(which) && edges < 400) begin
            if (inject && edges == 10) set_in(which, 1'b1, 25'd5);
            else if (inject && edges == 11) set_in(which, 1'b0, '0);
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic release_out(input int which);
        case (which)
            0: a_out_ready = 1'b1;
            1: d_out_ready = 1'b1;
            default: l_out_ready = 1'b1;
        endcase
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        d_out_ready = 1'b0;
        l_out_ready = 1'b0;
        case (which)
            0: check("ready_after_hs_a", a_in_ready, 1);
            1: check("ready_after_hs_d", d_in_ready, 1);
            default: check("ready_after_hs_l", l_in_ready, 1);
        endcase
        check("valid_after_hs", valid_of(which), 0);
    endtask

    initial begin
        int edges;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_eval_x", a_eval_x, 0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", a_in_ready, 1);
        check("rel_out_x", a_out_x, 0);
        check("rel_out_res", a_out_res, 0);
        check("rel_out_miss", a_out_miss, 0);

        // f(x)=x, target 1000, with an ignored second request mid-search
        a_mode = 0;
        request(0, 25'd1000, 1'b1, edges);
        check("x1000_latency", edges, 100);
        check("x1000_out_x", a_out_x, 1000);
        check("x1000_out_res", longint'($signed(a_out_res)), 0);
        check("x1000_out_miss", a_out_miss, 0);
        release_out(0);

        // f(x)=2x, target 1001, with 10 cycles of backpressure
        a_mode = 1;
        request(0, 25'd1001, 1'b0, edges);
        check("2x1001_latency", edges, 100);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", a_out_valid, 1);
            check("bp_out_x", a_out_x, 500);
            check("bp_out_res", longint'($signed(a_out_res)), 1);
            check("bp_in_ready", a_in_ready, 0);
        end
        check("2x1001_out_miss", a_out_miss, 0);
        release_out(0);

        // f(x)=2x, unreachable negative target
        request(0, -25'sd5, 1'b0, edges);
        check("2xneg_out_x", a_out_x, 0);
        check("2xneg_out_res", longint'($signed(a_out_res)), -5);
        check("2xneg_out_miss", a_out_miss, 1);
        release_out(0);

        // f(x)=x, maximum target
        a_mode = 0;
        request(0, 25'd16777215, 1'b0, edges);
        check("xmax_out_x", a_out_x, 16777215);
        check("xmax_out_res", longint'($signed(a_out_res)), 0);
        check("xmax_out_miss", a_out_miss, 0);
        release_out(0);

        // Reset pulse at edge 40 of a search
        set_in(0, 1'b1, 25'd1000);
        @(posedge clk); #1;
        set_in(0, 1'b0, '0);
        repeat (40) @(posedge clk);
        #1;
        check("midrst_busy", a_in_ready, 0);
        rst_b = 1'b0;
        #1;
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_eval_x", a_eval_x, 0);
        check("midrst_in_ready", a_in_ready, 1);
        #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        request(0, 25'd1000, 1'b0, edges);
        check("postrst_latency", edges, 100);
        check("postrst_out_x", a_out_x, 1000);
        release_out(0);

        // Decreasing build, f(x)=-x
        request(1, -25'sd300, 1'b0, edges);
        check("dec_latency", edges, 100);
        check("dec_out_x", d_out_x, 300);
        check("dec_out_res", longint'($signed(d_out_res)), 0);
        check("dec_out_miss", d_out_miss, 0);
        release_out(1);

        // LAT=5 build, f(x)=x
        request(2, 25'd77, 1'b0, edges);
        check("lat5_latency", edges, 150);
        check("lat5_out_x", l_out_x, 77);
        check("lat5_out_res", longint'($signed(l_out_res)), 0);
        release_out(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
